// File: rtl/serial_echo_pkg.sv
// Shared definitions for serial_transform_echo: transmit FSM encoding,
// transform mode constants and the word transform itself.
package serial_echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_REQ   = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_t;

  localparam int MODE_ECHO    = 0;
  localparam int MODE_ADD     = 1;
  localparam int MODE_INVERT  = 2;
  localparam int MODE_REVERSE = 3;

  localparam int XFORM_W = 64;

  // Works on a 64-bit carrier; only the low 'width' bits are meaningful, so
  // the add wraps modulo 2^width once the mask is applied.
  function automatic logic [XFORM_W-1:0] transform(
    input logic [XFORM_W-1:0] word,
    input int                 width,
    input int                 mode,
    input logic [XFORM_W-1:0] addend
  );
    logic [XFORM_W-1:0] mask;
    logic [XFORM_W-1:0] w;
    logic [XFORM_W-1:0] rev;
    logic [XFORM_W-1:0] r;
    mask = (width >= XFORM_W) ? '1 : ((XFORM_W'(1) << width) - XFORM_W'(1));
    w    = word & mask;
    rev  = {<<{w}};
    case (mode)
      MODE_ADD:     r = w + addend;
      MODE_INVERT:  r = ~w;
      MODE_REVERSE: r = rev >> (XFORM_W - width);
      default:      r = w;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/echo_sync_fifo.sv
// Synchronous FIFO with show-ahead read data, full/empty flags and fill level.
// A write while full is accepted only when a read happens in the same cycle.
module echo_sync_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUF_DEPTH  = 8,
  localparam int AW         = $clog2(BUF_DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [LW-1:0]         level
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full    = (level == LW'(BUF_DEPTH));
  assign empty   = (level == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_transform_echo.sv
// Echoes words from a serial core back to it through a FIFO and a transform.
// Define SERIAL_ECHO_STATS_EN to add saturating rx/tx/drop counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no session; waiting for a buffered word
// LOAD     | pop one word, register transformed tx_data, raise tx_data_ready
// REQ      | hold tx_data_ready until tx_data_copied or the copy timeout
// DRAIN    | wait for tx_busy low, then close the session
module serial_transform_echo
  import serial_echo_pkg::*;
#(
  parameter  int DATA_WIDTH      = 8,
  parameter  int BUF_DEPTH       = 8,
  parameter  int MODE            = 1,
  parameter  int ADD_VALUE       = 1,
  parameter  int LED_HOLD_CYCLES = 10000000,
  parameter  int COPY_TIMEOUT    = 65535,
  localparam int LW              = $clog2(BUF_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_byte_received,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_read,
  output logic                  tx_transaction,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_ready,
  input  logic                  tx_data_copied,
  input  logic                  tx_busy,
  output logic [LW-1:0]         buf_level,
  output logic                  overflow,
  output logic                  timeout_err,
`ifdef SERIAL_ECHO_STATS_EN
  output logic [15:0]           rx_count,
  output logic [15:0]           tx_count,
  output logic [15:0]           drop_count,
`endif
  output logic                  rx_led,
  output logic                  tx_led
);

  localparam int TO_W  = (COPY_TIMEOUT > 1) ? $clog2(COPY_TIMEOUT) : 1;
  localparam int LED_W = (LED_HOLD_CYCLES > 1) ? $clog2(LED_HOLD_CYCLES + 1) : 1;

  tx_state_t             state;
  logic [TO_W-1:0]       copy_timer;
  logic [LED_W-1:0]      rx_led_cnt;
  logic [LED_W-1:0]      tx_led_cnt;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [DATA_WIDTH-1:0] xform_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  assign pop  = (state == ST_LOAD);
  assign drop = rx_byte_received && fifo_full && !pop;

  assign xform_word = DATA_WIDTH'(transform(XFORM_W'(fifo_rd_data), DATA_WIDTH, MODE,
                                            XFORM_W'(ADD_VALUE)));

  echo_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_byte_received),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (buf_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_read  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_read <= rx_byte_received;
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      tx_transaction <= 1'b0;
      tx_data        <= '0;
      tx_data_ready  <= 1'b0;
      timeout_err    <= 1'b0;
      copy_timer     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            tx_transaction <= 1'b1;
            state          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_data       <= xform_word;
          tx_data_ready <= 1'b1;
          copy_timer    <= TO_W'(COPY_TIMEOUT - 1);
          state         <= ST_REQ;
        end
        ST_REQ: begin
          if (tx_data_copied) begin
            tx_data_ready <= 1'b0;
            state         <= ST_DRAIN;
          end else if (copy_timer == '0) begin
            // The popped word is abandoned; the core never latched it.
            tx_data_ready <= 1'b0;
            timeout_err   <= 1'b1;
            state         <= ST_DRAIN;
          end else begin
            copy_timer <= copy_timer - TO_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            tx_transaction <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Activity LEDs: a new event reloads the hold timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_led_cnt <= '0;
      tx_led_cnt <= '0;
    end else begin
      if (rx_byte_received)      rx_led_cnt <= LED_W'(LED_HOLD_CYCLES);
      else if (rx_led_cnt != '0) rx_led_cnt <= rx_led_cnt - LED_W'(1);
      if (pop)                   tx_led_cnt <= LED_W'(LED_HOLD_CYCLES);
      else if (tx_led_cnt != '0) tx_led_cnt <= tx_led_cnt - LED_W'(1);
    end
  end

  assign rx_led = (rx_led_cnt == '0);
  assign tx_led = (tx_led_cnt == '0);

`ifdef SERIAL_ECHO_STATS_EN
  logic push_ok;
  logic copy_seen;

  assign push_ok   = rx_byte_received && !drop;
  assign copy_seen = (state == ST_REQ) && tx_data_copied;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count   <= '0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (push_ok && rx_count != 16'hFFFF)     rx_count   <= rx_count + 16'd1;
      if (copy_seen && tx_count != 16'hFFFF)   tx_count   <= tx_count + 16'd1;
      if (drop && drop_count != 16'hFFFF)      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_transform_echo.sv
// Bench for serial_transform_echo: three instances (MODE 1/2/3) share stimulus;
// a scoreboard checks every presented word against a reference model.
module tb_serial_transform_echo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_byte_received;
  logic [7:0] rx_data;
  logic       tx_data_copied;
  logic       tx_busy;

  logic       rx_read        [3];
  logic       tx_transaction [3];
  logic [7:0] tx_data        [3];
  logic       tx_data_ready  [3];
  logic [2:0] buf_level      [3];
  logic       overflow       [3];
  logic       timeout_err    [3];
  logic       rx_led         [3];
  logic       tx_led         [3];

  int         asserts  = 0;
  int         failures = 0;
  logic [7:0] exp_q [3][$];
  logic       ready_q [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_transform_echo #(
      .DATA_WIDTH      (8),
      .BUF_DEPTH       (4),
      .MODE            (g + 1),
      .ADD_VALUE       (1),
      .LED_HOLD_CYCLES (5),
      .COPY_TIMEOUT    (16)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .rx_byte_received (rx_byte_received),
      .rx_data          (rx_data),
      .rx_read          (rx_read[g]),
      .tx_transaction   (tx_transaction[g]),
      .tx_data          (tx_data[g]),
      .tx_data_ready    (tx_data_ready[g]),
      .tx_data_copied   (tx_data_copied),
      .tx_busy          (tx_busy),
      .buf_level        (buf_level[g]),
      .overflow         (overflow[g]),
      .timeout_err      (timeout_err[g]),
      .rx_led           (rx_led[g]),
      .tx_led           (tx_led[g])
    );
  end

  function automatic logic [7:0] model(int mode, logic [7:0] d);
    logic [7:0] r;
    case (mode)
      1:       r = 8'((int'(d) + 1) % 256);
      2:       r = 8'hFF - d;
      default: r = {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
    endcase
    return r;
  endfunction

  function automatic logic [17:0] outs(int k);
    return {rx_read[k], tx_transaction[k], tx_data_ready[k], tx_data[k], buf_level[k],
            overflow[k], timeout_err[k], rx_led[k], tx_led[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    for (int k = 0; k < 3; k++) exp_q[k].delete();
  endtask

  task automatic sb_monitor();
    logic [7:0] want;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          ready_q[k] = 1'b0;
        end else begin
          if (tx_data_ready[k] && !ready_q[k]) begin
            asserts++;
            if (exp_q[k].size() == 0) begin
              failures++;
              $display("FAIL sb_unexpected dut%0d got %h with nothing expected", k, tx_data[k]);
            end else begin
              want = exp_q[k].pop_front();
              if (tx_data[k] !== want) begin
                failures++;
                $display("FAIL sb_data dut%0d got %h want %h", k, tx_data[k], want);
              end
            end
          end
          ready_q[k] = tx_data_ready[k];
        end
      end
    end
  endtask

  task automatic push_word(input logic [7:0] d, input bit keep);
    if (keep) for (int k = 0; k < 3; k++) exp_q[k].push_back(model(k + 1, d));
    rx_byte_received = 1'b1;
    rx_data          = d;
    tick();
    rx_byte_received = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_data_ready[0] && n < 40) begin
      tick();
      n++;
    end
    asserts++;
    if (tx_data_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready got %b want 1 within 40 cycles", tx_data_ready[0]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_transaction[0] && n < 40) begin
      tick();
      n++;
    end
    asserts++;
    if (tx_transaction[0] !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle tx_transaction got %b want 0 within 40 cycles", tx_transaction[0]);
    end
  endtask

  task automatic copy_and_drain();
    tx_data_copied = 1'b1;
    tick();
    tx_data_copied = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_queues();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if (outs(k) !== 18'h00003) begin
        failures++;
        $display("FAIL reset_outs dut%0d got %h want %h", k, outs(k), 18'h00003);
      end
    end
    rst = 1'b0;
    clear_queues();
    tick();
  endtask

  task automatic test_echo_basic();
    push_word(8'h41, 1'b1);
    asserts++;
    if (rx_read[0] !== 1'b1) begin
      failures++; $display("FAIL basic_rx_read_pulse got %b want 1", rx_read[0]);
    end
    asserts++;
    if (buf_level[0] !== 3'd1) begin
      failures++; $display("FAIL basic_level got %0d want 1", buf_level[0]);
    end
    asserts++;
    if (rx_led[0] !== 1'b0) begin
      failures++; $display("FAIL basic_rx_led got %b want 0", rx_led[0]);
    end
    tick();
    asserts++;
    if (rx_read[0] !== 1'b0 || tx_data_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_cycle2 rx_read %b ready %b want 0 0", rx_read[0], tx_data_ready[0]);
    end
    tick();
    asserts++;
    if (tx_data_ready[0] !== 1'b1 || tx_data[0] !== 8'h42 || tx_transaction[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency ready %b data %h trans %b want 1 42 1",
               tx_data_ready[0], tx_data[0], tx_transaction[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      asserts++;
      if (tx_data_ready[0] !== 1'b1 || tx_data[0] !== 8'h42) begin
        failures++;
        $display("FAIL basic_hold ready %b data %h want 1 42", tx_data_ready[0], tx_data[0]);
      end
    end
    tx_data_copied = 1'b1;
    tick();
    tx_data_copied = 1'b0;
    asserts++;
    if (tx_data_ready[0] !== 1'b0) begin
      failures++; $display("FAIL basic_ready_drop got %b want 0", tx_data_ready[0]);
    end
    tick();
    asserts++;
    if (tx_transaction[0] !== 1'b0) begin
      failures++; $display("FAIL basic_trans_drop got %b want 0", tx_transaction[0]);
    end
  endtask

  task automatic test_transforms();
    logic [7:0] in_v [3];
    logic [7:0] want [3][3];
    in_v = '{8'hFF, 8'h0F, 8'h01};
    want = '{'{8'h00, 8'h00, 8'hFF}, '{8'h10, 8'hF0, 8'hF0}, '{8'h02, 8'hFE, 8'h80}};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_word(in_v[i], 1'b1);
      wait_ready();
      for (int k = 0; k < 3; k++) begin
        asserts++;
        if (tx_data[k] !== want[i][k]) begin
          failures++;
          $display("FAIL xform mode%0d in %h got %h want %h", k + 1, in_v[i], tx_data[k], want[i][k]);
        end
      end
      copy_and_drain();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    push_word(8'h10, 1'b1);
    wait_ready();
    tx_busy        = 1'b1;
    tx_data_copied = 1'b1;
    tick();
    tx_data_copied = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'(8'h20 + i), i < 4);
    asserts++;
    if (buf_level[0] !== 3'd4 || overflow[0] !== 1'b1 || rx_read[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_state level %0d ovf %b rx_read %b want 4 1 1",
               buf_level[0], overflow[0], rx_read[0]);
    end
    tick();
    asserts++;
    if (rx_read[0] !== 1'b0) begin
      failures++; $display("FAIL ovf_rx_read_end got %b want 0", rx_read[0]);
    end
    tx_busy = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      copy_and_drain();
    end
    asserts++;
    if (buf_level[0] !== 3'd0 || overflow[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after level %0d ovf %b want 0 1", buf_level[0], overflow[0]);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    push_word(8'h30, 1'b1);
    wait_ready();
    tx_busy        = 1'b1;
    tx_data_copied = 1'b1;
    tick();
    tx_data_copied = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h31 + i), 1'b1);
    asserts++;
    if (buf_level[0] !== 3'd4 || overflow[0] !== 1'b0) begin
      failures++;
      $display("FAIL full_fill level %0d ovf %b want 4 0", buf_level[0], overflow[0]);
    end
    tx_busy = 1'b0;
    tick();
    tick();
    push_word(8'h35, 1'b1);
    asserts++;
    if (buf_level[0] !== 3'd4 || overflow[0] !== 1'b0 || tx_data_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL full_push_pop level %0d ovf %b ready %b want 4 0 1",
               buf_level[0], overflow[0], tx_data_ready[0]);
    end
    for (int i = 0; i < 5; i++) begin
      wait_ready();
      copy_and_drain();
    end
    asserts++;
    if (buf_level[0] !== 3'd0) begin
      failures++; $display("FAIL full_drained level %0d want 0", buf_level[0]);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    push_word(8'h50, 1'b1);
    wait_ready();
    while (tx_data_ready[0] && n < 40) begin
      n++;
      tick();
    end
    asserts++;
    if (n != 16) begin
      failures++; $display("FAIL timeout_len ready cycles %0d want 16", n);
    end
    asserts++;
    if (timeout_err[0] !== 1'b1) begin
      failures++; $display("FAIL timeout_err got %b want 1", timeout_err[0]);
    end
    wait_idle();
    push_word(8'h51, 1'b1);
    wait_ready();
    asserts++;
    if (tx_data[0] !== 8'h52) begin
      failures++; $display("FAIL timeout_next got %h want 52", tx_data[0]);
    end
    copy_and_drain();
    asserts++;
    if (timeout_err[0] !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky got %b want 1", timeout_err[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_word(8'h60, 1'b1);
    push_word(8'h61, 1'b1);
    wait_ready();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if (outs(k) !== 18'h00003) begin
        failures++;
        $display("FAIL midreset_outs dut%0d got %h want %h", k, outs(k), 18'h00003);
      end
    end
    clear_queues();
    rst = 1'b0;
    repeat (4) tick();
    asserts++;
    if (tx_data_ready[0] !== 1'b0 || buf_level[0] !== 3'd0 || tx_transaction[0] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_stale ready %b level %0d trans %b want 0 0 0",
               tx_data_ready[0], buf_level[0], tx_transaction[0]);
    end
    push_word(8'h62, 1'b1);
    wait_ready();
    copy_and_drain();
  endtask

  task automatic test_led();
    int n = 0;
    do_reset();
    push_word(8'h70, 1'b1);
    while (!rx_led[0] && n < 20) begin
      n++;
      tick();
    end
    asserts++;
    if (n != 5) begin
      failures++; $display("FAIL rx_led_hold low cycles %0d want 5", n);
    end
    asserts++;
    if (tx_led[0] !== 1'b0) begin
      failures++; $display("FAIL tx_led_on got %b want 0", tx_led[0]);
    end
    wait_ready();
    copy_and_drain();
  endtask

  initial begin
    rst              = 1'b1;
    rx_byte_received = 1'b0;
    rx_data          = 8'h00;
    tx_data_copied   = 1'b0;
    tx_busy          = 1'b0;
    for (int k = 0; k < 3; k++) ready_q[k] = 1'b0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_echo_basic();
    test_transforms();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_reset_mid();
    test_led();
    repeat (2) tick();
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if (exp_q[k].size() != 0) begin
        failures++;
        $display("FAIL sb_leftover dut%0d pending %0d want 0", k, exp_q[k].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
